mpc_kob: RTL

- Per-channel keep-order buffer (KOB) on the response path of the multi-port cache.
- Hands out a rob_id for each load a channel issues toward the banks.
- Accepts out-of-order bank responses (rc_rsp_t) tagged with channel_id/rob_id.
- Returns read data to the channel strictly in issue order as channel_rsp_t, using a valid/ready handshake.
- One instance per channel, between the bank response crossbar and the channel port.

---
 rtl/mpc_kob_pkg.sv | 28 ++
 rtl/mpc_kob_ptr.sv | 34 +++
 rtl/mpc_kob.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mpc_kob_pkg.sv
// Shared types for the multi-port cache keep-order buffer.
package mpc_kob_pkg;

    localparam int unsigned MPC_ROB_ID_W     = 3;
    localparam int unsigned MPC_CHANNEL_ID_W = 2;
    localparam int unsigned MPC_DATA_W       = 128;

    typedef logic [MPC_ROB_ID_W-1:0]     rob_id_t;
    typedef logic [MPC_CHANNEL_ID_W-1:0] channel_id_t;

    // Bank response as broadcast by the response crossbar.
    typedef struct packed {
        channel_id_t             channel_id;
        rob_id_t                 rob_id;
        logic [MPC_DATA_W-1:0]   rdata;
    } rc_rsp_t;

    // Response delivered to the channel port.
    typedef struct packed {
        logic [MPC_DATA_W-1:0] rdata;
    } channel_rsp_t;

    // Buffer depth must be a power of two addressable by a 3-bit rob_id.
    function automatic logic kob_size_ok(int unsigned n);
        return (n == 2) || (n == 4) || (n == 8);
    endfunction

endpackage

// File: rtl/mpc_kob_ptr.sv
// Circular pointer with an extra wrap bit so equal indices can be told apart as full/empty.
module mpc_kob_ptr #(
    parameter int unsigned IdxW = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    output logic [IdxW-1:0] idx_o,
    output logic            wrap_o
);

    logic [IdxW:0] ptr_q, ptr_d;

    // Advance by one; the natural binary overflow toggles the wrap bit.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + {{IdxW{1'b0}}, 1'b1};
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign idx_o  = ptr_q[IdxW-1:0];
    assign wrap_o = ptr_q[IdxW];

endmodule

// File: rtl/mpc_kob.sv
// Keep-order buffer: hands out rob_ids, accepts out-of-order bank responses and
// returns them to the channel strictly in issue order.
module mpc_kob
    import mpc_kob_pkg::*;
#(
    parameter int unsigned KOB_SIZE   = 8,
    parameter channel_id_t CHANNEL_ID = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         alloc_valid_i,
    output logic         alloc_ready_o,
    output rob_id_t      alloc_id_o,
    input  logic         rsp_valid_i,
    input  rc_rsp_t      rsp_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output channel_rsp_t out_rsp_o,
    output logic [3:0]   count_o,
    output logic         empty_o,
    output logic         err_o
);

    localparam int unsigned IdxW = $clog2(KOB_SIZE);

    if (!kob_size_ok(KOB_SIZE)) begin : g_bad_size
        $error("mpc_kob: KOB_SIZE must be 2, 4 or 8");
    end

    logic [IdxW-1:0] head_idx, tail_idx;
    logic            head_wrap, tail_wrap;

    logic [KOB_SIZE-1:0]   alloc_q, alloc_d;
    logic [KOB_SIZE-1:0]   filled_q, filled_d;
    logic [MPC_DATA_W-1:0] data_q [KOB_SIZE];
    logic [MPC_DATA_W-1:0] data_d [KOB_SIZE];
    logic                  err_q, err_d;

    logic                full;
    logic                alloc_fire;
    logic                pop;
    logic                head_valid;
    logic                rsp_hit;
    logic [KOB_SIZE-1:0] rsp_sel;
    logic [IdxW:0]       cnt;

    mpc_kob_ptr #(
        .IdxW (IdxW)
    ) u_head_ptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (pop),
        .idx_o  (head_idx),
        .wrap_o (head_wrap)
    );

    mpc_kob_ptr #(
        .IdxW (IdxW)
    ) u_tail_ptr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .inc_i  (alloc_fire),
        .idx_o  (tail_idx),
        .wrap_o (tail_wrap)
    );

    // Handshake decode from start-of-cycle state; a same-cycle pop never frees a slot early.
    always_comb begin
        full       = (head_idx == tail_idx) && (head_wrap != tail_wrap);
        head_valid = alloc_q[head_idx] && filled_q[head_idx];
        alloc_fire = alloc_valid_i && !full;
        pop        = head_valid && out_ready_i;
        rsp_hit    = rsp_valid_i && (rsp_i.channel_id == CHANNEL_ID);
    end

    // A response is accepted only into an allocated, still-empty entry; ids past
    // KOB_SIZE match no entry and therefore fall through to the error path.
    always_comb begin
        rsp_sel = '0;
        for (int i = 0; i < KOB_SIZE; i++) begin
            rsp_sel[i] = rsp_hit && (rsp_i.rob_id == rob_id_t'(i)) && alloc_q[i] && !filled_q[i];
        end
        err_d = err_q | (rsp_hit && !(|rsp_sel));
    end

    // Entry next-state: alloc, fill and pop always target distinct entries.
    always_comb begin
        alloc_d  = alloc_q;
        filled_d = filled_q;
        data_d   = data_q;
        for (int i = 0; i < KOB_SIZE; i++) begin
            if (alloc_fire && (tail_idx == IdxW'(i))) begin
                alloc_d[i]  = 1'b1;
                filled_d[i] = 1'b0;
            end
            if (rsp_sel[i]) begin
                filled_d[i] = 1'b1;
                data_d[i]   = rsp_i.rdata;
            end
            if (pop && (head_idx == IdxW'(i))) begin
                alloc_d[i]  = 1'b0;
                filled_d[i] = 1'b0;
            end
        end
    end

    // Entry status and sticky error with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alloc_q  <= '0;
            filled_q <= '0;
            err_q    <= 1'b0;
        end else begin
            alloc_q  <= alloc_d;
            filled_q <= filled_d;
            err_q    <= err_d;
        end
    end

    // Payload storage; never observed unless the filled bit is set, so no reset.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    // Registered-state outputs only; nothing here depends on rsp_i.
    always_comb begin
        cnt             = {tail_wrap, tail_idx} - {head_wrap, head_idx};
        alloc_ready_o   = !full;
        alloc_id_o      = rob_id_t'(tail_idx);
        out_valid_o     = head_valid;
        out_rsp_o.rdata = head_valid ? data_q[head_idx] : '0;
        count_o         = 4'(cnt);
        empty_o         = (cnt == '0);
        err_o           = err_q;
    end

endmodule
